// File: rtl/clock_step_control_if.sv
// clock_step_control_if: button, halt and clock-enable signals between the
// step controller and the machine/user side driving it.
interface clock_step_control_if;
    logic btn_step;
    logic btn_mode;
    logic hlt;
    logic clk_en;
    logic run_mode;
    logic halted;
    modport master (output btn_step, btn_mode, hlt, input clk_en, run_mode, halted);
    modport slave (input btn_step, btn_mode, hlt, output clk_en, run_mode, halted);
endinterface

// File: rtl/clock_step_control.sv
// clock_step_control: debounced single-step / free-run clock-enable generator
// with a sticky halt state cleared only by reset.
module clock_step_control #(
    parameter int DIV_RATIO       = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input logic                 clk,
    input logic                 rst,
    clock_step_control_if.slave bus
);
    localparam int DW = $clog2(DIV_RATIO);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATIO - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] S_STEP = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]    w_btn;
    logic [1:0]    r_s1;
    logic [1:0]    r_s2;
    logic [1:0]    r_db;
    logic [1:0]    r_press;
    logic [CW-1:0] r_cnt [2];
    logic [1:0]    r_state;
    logic [DW-1:0] r_div;
    logic          r_clk_en;

    assign w_btn = {bus.btn_mode, bus.btn_step};

    // Index 0 is the step button, index 1 the mode button; r_press fires on
    // the same edge the debounced value rises, so it lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_db    <= '0;
            r_press <= '0;
            for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
        end else begin
            r_s1    <= w_btn;
            r_s2    <= r_s1;
            r_press <= '0;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_cnt[i]   <= '0;
                    r_db[i]    <= r_s2[i];
                    r_press[i] <= r_s2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Mode press wins over a coincident step press; hlt overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_STEP;
            r_clk_en <= 1'b0;
            r_div    <= DIV_LAST;
        end else if (bus.hlt || r_state == S_HALT) begin
            r_state  <= S_HALT;
            r_clk_en <= 1'b0;
        end else if (r_state == S_STEP) begin
            r_clk_en <= r_press[0] & ~r_press[1];
            if (r_press[1]) begin
                r_state <= S_RUN;
                r_div   <= DIV_LAST;
            end
        end else begin
            r_clk_en <= ~r_press[1] && r_div == '0;
            r_div    <= (r_div == '0) ? DIV_LAST : r_div - DW'(1);
            if (r_press[1]) r_state <= S_STEP;
        end
    end

    assign bus.clk_en   = r_clk_en;
    assign bus.run_mode = r_state == S_RUN;
    assign bus.halted   = r_state == S_HALT;
endmodule

// File: doc/clock_step_control.md
CLOCK_STEP_CONTROL -- requirements
Module: clock_step_control

Interface
REQ-001 SHALL have parameter DIV_RATIO, default 100000000, meaning clk cycles between clk_en pulses in RUN mode (legal >= 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable synchronized cycles required to accept a button change (legal >= 2).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-005 SHALL have port btn_step, input, 1 bit, meaning raw asynchronous step pushbutton, active-high.
REQ-006 SHALL have port btn_mode, input, 1 bit, meaning raw asynchronous run/step toggle pushbutton, active-high.
REQ-007 SHALL have port hlt, input, 1 bit, meaning synchronous CPU halt request, already in the clk domain.
REQ-008 SHALL have port clk_en, output, 1 bit, meaning registered one-cycle clock-enable pulses to the machine.
REQ-009 SHALL have port run_mode, output, 1 bit, meaning 1 in RUN state, 0 otherwise.
REQ-010 SHALL have port halted, output, 1 bit, meaning 1 in HALT state, 0 otherwise.

Function
REQ-011 SHALL pass each button through its own two-flop synchronizer before any other use.
REQ-012 SHALL debounce each synchronized button independently: counter cleared whenever the synchronized value equals the debounced value; incremented while they differ; debounced value takes the synchronized value on the edge at which the counter would reach DEBOUNCE_CYCLES, and the counter clears.
REQ-013 SHALL treat a debounced 0->1 transition as a press event, valid for exactly one cycle; releases generate no event.
REQ-014 SHALL implement a three-state FSM: STEP, RUN, HALT.
REQ-015 STEP: a step press SHALL produce clk_en=1 in exactly the following cycle, one cycle wide.
REQ-016 STEP: a mode press SHALL move to RUN and load the divider with DIV_RATIO-1.
REQ-017 RUN: divider SHALL decrement once per cycle; when it equals 0, clk_en SHALL be 1 next cycle and the divider reloads DIV_RATIO-1; pulse period exactly DIV_RATIO cycles; first pulse DIV_RATIO cycles after entering RUN.
REQ-018 RUN: step presses SHALL be ignored; a mode press SHALL move to STEP with no further clk_en pulses, including one due on that cycle.
REQ-019 Simultaneous step and mode press events SHALL act on mode only; the step event is discarded.
REQ-020 hlt=1 in any state SHALL move to HALT on that edge and force clk_en=0 from the next cycle, overriding any pending or coincident pulse.
REQ-021 HALT SHALL be sticky: both buttons and hlt deassertion ignored; exit only via rst.
REQ-022 Divider width SHALL be $clog2(DIV_RATIO); debounce counter width $clog2(DEBOUNCE_CYCLES+1); no counter SHALL wrap.
REQ-023 Exact latency, raw button rising and held stable -> clk_en high in STEP: 2 + DEBOUNCE_CYCLES + 1 clk cycles.

Reset
REQ-024 rst=1 SHALL asynchronously force: state STEP, clk_en=0, run_mode=0, halted=0, divider=DIV_RATIO-1, debounced values=0, debounce counters=0, synchronizer flops=0.
REQ-025 A button held high through rst deassertion SHALL register as a single press once debounced.
REQ-026 rst asserted mid-debounce or mid-divide SHALL discard all progress; no clk_en pulse in the cycle after release.

Verification (DIV_RATIO=5, DEBOUNCE_CYCLES=4)
REQ-027 Step press: btn_step high 20 cycles in STEP -> exactly one clk_en pulse, 7 cycles after rise; none on release.
REQ-028 Bounce: btn_step toggling every 2 cycles for 16 cycles, then low -> zero clk_en pulses.
REQ-029 Run: mode press, then hold idle 30 cycles -> run_mode=1; clk_en pulses exactly every 5 cycles, first at 5 cycles after run_mode rises; second mode press -> run_mode=0, pulses stop.
REQ-030 Simultaneous press: btn_step and btn_mode rise same cycle in STEP -> RUN entered, no immediate step pulse.
REQ-031 Halt: hlt=1 for one cycle during RUN on the cycle a pulse is due -> clk_en stays 0, halted=1, remains halted after hlt=0 and further button presses until rst.
REQ-032 Reset mid-run: rst pulse while divider=2 -> all outputs 0 next cycle, state STEP, no clk_en until a new step press.
